// File: rtl/clock_div_prog_if.sv
// Control/status bundle for the programmable clock divider.
//   en        per-channel run enable
//   div_value channel k divisor at [k*WIDTH +: WIDTH]
//   div_load  per-channel one-cycle load request
//   div_ack   one-cycle pulse: new divisor applied
//   div_err   one-cycle pulse: load rejected (value 0 or 1)
//   clk_out   divided clocks, 50% duty
//   tick      one-cycle pulse on each clk_out rising period start
// master drives the requests; slave is the divider.
interface clock_div_prog_if #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned WIDTH = 16
);
    logic [NCH-1:0]       en;
    logic [NCH*WIDTH-1:0] div_value;
    logic [NCH-1:0]       div_load;
    logic [NCH-1:0]       div_ack;
    logic [NCH-1:0]       div_err;
    logic [NCH-1:0]       clk_out;
    logic [NCH-1:0]       tick;

    modport master (
        output en, div_value, div_load,
        input  div_ack, div_err, clk_out, tick
    );

    modport slave (
        input  en, div_value, div_load,
        output div_ack, div_err, clk_out, tick
    );
endinterface

// File: rtl/clock_div_prog.sv
// Multi-channel runtime-programmable integer clock divider.
// Each channel divides clock by D in 2..2^WIDTH-1 with 50% duty for even
// and odd D. Divisor changes are applied only on a period boundary and are
// acknowledged with div_ack; invalid divisors (0, 1) pulse div_err.
// Ports:
//   clock  system clock (rising edge; falling edge for the odd-D half flop)
//   rst    asynchronous active-low reset
//   bus    clock_div_prog_if.slave (en, div_value, div_load in;
//          div_ack, div_err, clk_out, tick out)
module clock_div_prog #(
    parameter int unsigned NCH         = 2,
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             clock,
    input  logic             rst,
    clock_div_prog_if.slave  bus
);

    // One extra bit so (cur_div + 1) cannot overflow at the maximum divisor.
    localparam int unsigned W1 = WIDTH + 1;
    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic [NCH-1:0] w_ack;
    logic [NCH-1:0] w_err;
    logic [NCH-1:0] w_tick;
    logic [NCH-1:0] w_clk;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        state_t           r_state;
        logic [WIDTH-1:0] r_cnt;
        logic [WIDTH-1:0] r_cur_div;
        logic [WIDTH-1:0] r_pend_div;
        logic             r_pend_vld;
        logic             r_out_p;
        logic             r_out_n;
        logic             r_tick;
        logic             r_ack;
        logic             r_err;

        logic [WIDTH-1:0] w_val;
        logic             w_val_ok;
        logic             w_boundary;
        logic [W1-1:0]    w_h;
        logic [W1-1:0]    w_cnt_inc;
        logic             w_hi_next;

        assign w_val      = bus.div_value[k*WIDTH +: WIDTH];
        assign w_val_ok   = (w_val > WIDTH'(1));
        assign w_h        = (W1'(r_cur_div) + W1'(1)) >> 1;
        assign w_cnt_inc  = W1'(r_cnt) + W1'(1);
        assign w_boundary = (r_cnt == (r_cur_div - WIDTH'(1)));
        assign w_hi_next  = (w_cnt_inc < w_h);

        // Channel sequencer: counter, divisor bookkeeping and rising-edge output.
        always_ff @(posedge clock or negedge rst) begin
            if (!rst) begin
                r_state    <= ST_IDLE;
                r_cnt      <= '0;
                r_cur_div  <= DEF_DIV;
                r_pend_div <= DEF_DIV;
                r_pend_vld <= 1'b0;
                r_out_p    <= 1'b0;
                r_tick     <= 1'b0;
                r_ack      <= 1'b0;
                r_err      <= 1'b0;
            end else begin
                r_tick <= 1'b0;
                r_ack  <= 1'b0;
                r_err  <= 1'b0;

                case (r_state)
                    ST_IDLE: begin
                        r_cnt   <= '0;
                        r_out_p <= 1'b0;
                        if (bus.en[k]) begin
                            r_state <= ST_RUN;
                            r_out_p <= 1'b1;
                            r_tick  <= 1'b1;
                        end
                    end

                    ST_RUN: begin
                        if (!w_boundary) begin
                            r_cnt   <= r_cnt + WIDTH'(1);
                            r_out_p <= w_hi_next;
                        end else begin
                            // Only a pending value set before this edge is applied here.
                            if (r_pend_vld) begin
                                r_cur_div  <= r_pend_div;
                                r_pend_vld <= 1'b0;
                                r_ack      <= 1'b1;
                            end
                            r_cnt <= '0;
                            if (bus.en[k]) begin
                                r_out_p <= 1'b1;
                                r_tick  <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                                r_out_p <= 1'b0;
                            end
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_out_p <= 1'b0;
                    end
                endcase

                // Load requests; placed last so a load on the boundary edge
                // re-arms the pending slot for the next boundary.
                if (bus.div_load[k]) begin
                    if (!w_val_ok) begin
                        r_err <= 1'b1;
                    end else if (r_state == ST_RUN) begin
                        r_pend_div <= w_val;
                        r_pend_vld <= 1'b1;
                    end else begin
                        r_cur_div  <= w_val;
                        r_pend_vld <= 1'b0;
                        r_ack      <= 1'b1;
                    end
                end
            end
        end

        // Half-cycle delayed copy of out_p; ANDed in for odd divisors.
        always_ff @(negedge clock or negedge rst) begin
            if (!rst) begin
                r_out_n <= 1'b0;
            end else begin
                r_out_n <= r_out_p;
            end
        end

        assign w_clk[k]  = r_cur_div[0] ? (r_out_p & r_out_n) : r_out_p;
        assign w_tick[k] = r_tick;
        assign w_ack[k]  = r_ack;
        assign w_err[k]  = r_err;
    end

    assign bus.clk_out = w_clk;
    assign bus.tick    = w_tick;
    assign bus.div_ack = w_ack;
    assign bus.div_err = w_err;

endmodule
